// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel tick timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ch_state_e;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   // 50 MHz / (833333 + 1) = 59.99 Hz frame tick
   localparam int unsigned LIMIT_60HZ_50MHZ = 833333;

   function automatic int unsigned ch_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tick_channel.sv
// One timer channel: IDLE/RUN/DONE FSM with its own counter, limit and mode.
module tick_channel
   import timer_pkg::*;
#(
   parameter int unsigned CNT_W         = 28,
   parameter int unsigned DEFAULT_LIMIT = LIMIT_60HZ_50MHZ,
   parameter int unsigned RUN_AT_RESET  = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ce,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_limit,
   input  logic             cfg_oneshot,
   input  logic             start,
   input  logic             stop,
   output logic             pulse,
   output logic             running,
   output logic             done
);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic             mode_q, mode_d;
   logic             pulse_q, pulse_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      limit_d = limit_q;
      mode_d  = mode_q;
      pulse_d = 1'b0;

      // Terminal test below reads limit_q/mode_q, so a same-cycle write applies next cycle
      if (cfg_we) begin
         limit_d = cfg_limit;
         mode_d  = cfg_oneshot;
      end

      if (stop) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (start) state_d = RUN;
            end
            RUN: begin
               if (start) begin
                  cnt_d = '0;
               end else if (ce) begin
                  if (cnt_q >= limit_q) begin
                     cnt_d   = '0;
                     pulse_d = 1'b1;
                     if (mode_q == MODE_ONESHOT) state_d = DONE;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            DONE: begin
               cnt_d = '0;
               if (start) state_d = RUN;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= (RUN_AT_RESET != 0) ? RUN : IDLE;
         cnt_q   <= '0;
         limit_q <= CNT_W'(DEFAULT_LIMIT);
         mode_q  <= MODE_PERIODIC;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         limit_q <= limit_d;
         mode_q  <= mode_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse   = pulse_q;
   assign running = (state_q == RUN);
   assign done    = (state_q == DONE);

endmodule

// File: rtl/multi_tick_timer.sv
// Bank of NUM_CH tick channels sharing one free-running prescaler.
module multi_tick_timer
   import timer_pkg::*;
#(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned CNT_W         = 28,
   parameter int unsigned PRESCALE      = 1,
   parameter int unsigned DEFAULT_LIMIT = LIMIT_60HZ_50MHZ,
   parameter int unsigned RUN_AT_RESET  = 1
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          cfg_we,
   input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]              cfg_limit,
   input  logic                          cfg_oneshot,
   input  logic [NUM_CH-1:0]             start,
   input  logic [NUM_CH-1:0]             stop,
   output logic [NUM_CH-1:0]             pulse,
   output logic [NUM_CH-1:0]             running,
   output logic [NUM_CH-1:0]             done
);

   localparam int unsigned CH_W  = ch_width(NUM_CH);
   localparam int unsigned PRE_W = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);

   logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
   logic              ce;
   logic [NUM_CH-1:0] ch_we;

   always_comb begin
      ce        = (pre_cnt_q == PRE_W'(PRESCALE - 1));
      pre_cnt_d = ce ? '0 : pre_cnt_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) pre_cnt_q <= '0;
      else          pre_cnt_q <= pre_cnt_d;
   end

   // Indices >= NUM_CH match no channel, so such writes are dropped
   always_comb begin
      ch_we = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tick_channel #(
         .CNT_W         (CNT_W),
         .DEFAULT_LIMIT (DEFAULT_LIMIT),
         .RUN_AT_RESET  (RUN_AT_RESET)
      ) u_ch (
         .clock       (clock),
         .reset_n     (reset_n),
         .ce          (ce),
         .cfg_we      (ch_we[g]),
         .cfg_limit   (cfg_limit),
         .cfg_oneshot (cfg_oneshot),
         .start       (start[g]),
         .stop        (stop[g]),
         .pulse       (pulse[g]),
         .running     (running[g]),
         .done        (done[g])
      );
   end

endmodule

// File: tb/tb_multi_tick_timer.sv
// Directed test of multi_tick_timer: two instances (PRESCALE=1 and PRESCALE=3).
module tb_multi_tick_timer;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   // instance A: NUM_CH=2, PRESCALE=1, DEFAULT_LIMIT=4, RUN_AT_RESET=1
   logic        reset_n;
   logic        cfg_we;
   logic [0:0]  cfg_ch;
   logic [7:0]  cfg_limit;
   logic        cfg_oneshot;
   logic [1:0]  start, stop;
   logic [1:0]  pulse, running, done;

   // instance B: NUM_CH=3, PRESCALE=3, DEFAULT_LIMIT=4, RUN_AT_RESET=0
   logic        b_reset_n;
   logic        b_cfg_we;
   logic [1:0]  b_cfg_ch;
   logic [7:0]  b_cfg_limit;
   logic        b_cfg_oneshot;
   logic [2:0]  b_start, b_stop;
   logic [2:0]  b_pulse, b_running, b_done;

   int n_checks = 0;
   int n_err    = 0;
   int n1;

   multi_tick_timer #(
      .NUM_CH(2), .CNT_W(8), .PRESCALE(1), .DEFAULT_LIMIT(4), .RUN_AT_RESET(1)
   ) dut_a (
      .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_limit(cfg_limit), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
      .pulse(pulse), .running(running), .done(done)
   );

   multi_tick_timer #(
      .NUM_CH(3), .CNT_W(8), .PRESCALE(3), .DEFAULT_LIMIT(4), .RUN_AT_RESET(0)
   ) dut_b (
      .clock(clock), .reset_n(b_reset_n), .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch),
      .cfg_limit(b_cfg_limit), .cfg_oneshot(b_cfg_oneshot), .start(b_start), .stop(b_stop),
      .pulse(b_pulse), .running(b_running), .done(b_done)
   );

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_limit = '0; cfg_oneshot = 1'b0;
      start = '0; stop = '0;
      b_reset_n = 1'b0; b_cfg_we = 1'b0; b_cfg_ch = '0; b_cfg_limit = '0; b_cfg_oneshot = 1'b0;
      b_start = '0; b_stop = '0;
      step; step;
      chk("rst_pulse", 32'(pulse), 0);
      chk("rst_running", 32'(running), 3);
      chk("rst_done", 32'(done), 0);
      chk("rst_b_running", 32'(b_running), 0);

      // 1: free-running period 5
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin step; chk("t1_quiet", 32'(pulse), 0); end
      step; chk("t1_first", 32'(pulse), 3);
      chk("t1_running", 32'(running), 3);
      for (int i = 0; i < 4; i++) begin step; chk("t1_quiet2", 32'(pulse), 0); end
      step; chk("t1_second", 32'(pulse), 3);

      // 2: ch0 one-shot limit 2
      cfg_we = 1'b1; cfg_ch = 1'b0; cfg_limit = 8'd2; cfg_oneshot = 1'b1;
      step; cfg_we = 1'b0;
      stop = 2'b01;
      step; stop = '0;
      chk("t2_stopped", 32'(running), 2);
      start = 2'b01;
      step; start = '0;
      chk("t2_started", 32'(running), 3);
      step; chk("t2_c1", 32'(pulse), 0);
      step; chk("t2_c2", 32'(pulse), 2);
      step; chk("t2_shot", 32'(pulse), 1);
      chk("t2_done", 32'(done), 1);
      chk("t2_running", 32'(running), 2);
      n1 = 0;
      for (int i = 0; i < 20; i++) begin
         step;
         chk("t2_no_refire", 32'(pulse[0]), 0);
         if (pulse[1]) n1++;
      end
      chk("t2_done_sticky", 32'(done), 1);
      chk("t2_ch1_count", 32'(n1), 4);

      // 4: start+stop together, then retrigger on ch1
      start = 2'b10; stop = 2'b10;
      step; start = '0; stop = '0;
      chk("t4_stop_wins", 32'(running), 0);
      chk("t4_no_pulse", 32'(pulse), 0);
      start = 2'b10;
      step; start = '0;
      chk("t4_run", 32'(running), 2);
      for (int i = 0; i < 3; i++) begin step; chk("t4_count", 32'(pulse[1]), 0); end
      start = 2'b10;
      step; start = '0;
      chk("t4_retrig", 32'(pulse[1]), 0);
      for (int i = 0; i < 4; i++) begin step; chk("t4_after", 32'(pulse[1]), 0); end
      step; chk("t4_pulse", 32'(pulse[1]), 1);
      for (int i = 0; i < 4; i++) begin step; chk("t4_q", 32'(pulse[1]), 0); end
      start = 2'b10;
      step; start = '0;
      chk("t4_retrig_terminal", 32'(pulse[1]), 0);
      for (int i = 0; i < 4; i++) begin step; chk("t4_q2", 32'(pulse[1]), 0); end
      step; chk("t4_pulse2", 32'(pulse[1]), 1);

      // 5: lower the limit below the current count on ch0
      cfg_we = 1'b1; cfg_ch = 1'b0; cfg_limit = 8'd9; cfg_oneshot = 1'b0; start = 2'b01;
      step; cfg_we = 1'b0; start = '0;
      chk("t5_running", 32'(running), 3);
      chk("t5_done_clr", 32'(done), 0);
      for (int i = 0; i < 7; i++) begin step; chk("t5_count", 32'(pulse[0]), 0); end
      cfg_we = 1'b1; cfg_ch = 1'b0; cfg_limit = 8'd3; cfg_oneshot = 1'b0;
      step; cfg_we = 1'b0;
      chk("t5_write_edge", 32'(pulse[0]), 0);
      step; chk("t5_fire", 32'(pulse[0]), 1);
      for (int i = 0; i < 3; i++) begin step; chk("t5_q", 32'(pulse[0]), 0); end
      step; chk("t5_period4", 32'(pulse[0]), 1);

      // 6: ch1 one-shot to DONE, then reset over a pending ch0 pulse
      cfg_we = 1'b1; cfg_ch = 1'b1; cfg_limit = 8'd1; cfg_oneshot = 1'b1; start = 2'b10;
      step; cfg_we = 1'b0; start = '0;
      chk("t6_retrig", 32'(pulse), 0);
      step; chk("t6_c1", 32'(pulse), 0);
      step; chk("t6_shot", 32'(pulse), 2);
      chk("t6_done", 32'(done), 2);
      chk("t6_running", 32'(running), 1);
      step; chk("t6_ch0", 32'(pulse), 1);
      step; step; step;
      reset_n = 1'b0;
      step; reset_n = 1'b1;
      chk("t6_rst_pulse", 32'(pulse), 0);
      chk("t6_rst_done", 32'(done), 0);
      chk("t6_rst_running", 32'(running), 3);
      for (int i = 0; i < 4; i++) begin step; chk("t6_quiet", 32'(pulse), 0); end
      step; chk("t6_first", 32'(pulse), 3);
      for (int i = 0; i < 4; i++) begin step; chk("t6_quiet2", 32'(pulse), 0); end
      step; chk("t6_periodic", 32'(pulse), 3);
      chk("t6_running2", 32'(running), 3);

      // 3: PRESCALE=3, limit 1 -> period 6
      b_reset_n = 1'b1;
      b_cfg_we = 1'b1; b_cfg_ch = 2'd0; b_cfg_limit = 8'd1; b_cfg_oneshot = 1'b0; b_start = 3'b001;
      step; b_cfg_we = 1'b0; b_start = '0;
      chk("t3_running", 32'(b_running), 1);
      for (int k = 2; k <= 12; k++) begin
         step;
         chk("t3_pre_period", 32'(b_pulse[0]), (k == 6 || k == 12) ? 1 : 0);
      end
      b_cfg_we = 1'b1; b_cfg_ch = 2'd3; b_cfg_limit = 8'd0;
      step; b_cfg_we = 1'b0;
      chk("t3_oob_c13", 32'(b_pulse), 0);
      for (int k = 14; k <= 18; k++) begin
         step;
         chk("t3_oob_ignored", 32'(b_pulse), (k == 18) ? 1 : 0);
      end
      chk("t3_running2", 32'(b_running), 1);
      b_cfg_we = 1'b1; b_cfg_ch = 2'd1; b_cfg_limit = 8'd0; b_cfg_oneshot = 1'b0; b_start = 3'b010;
      step; b_cfg_we = 1'b0; b_start = '0;
      for (int k = 20; k <= 24; k++) begin
         step;
         chk("t3_limit0", 32'(b_pulse[1]), (k == 21 || k == 24) ? 1 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
